// File: rtl/gf2_digit_serial_mul.sv
// Digit-serial carry-less multiplier over GF(2)[x]: c = a*b, D bits of a per cycle, MSB digit first.
// Optional build macro GF2_MUL_ACC_EN adds port acc_en, which selects c = a*b XOR previous c.
module gf2_digit_serial_mul #(
    parameter int AW = 41,
    parameter int M  = 163,
    parameter int D  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       a,
    input  logic [M-1:0]        b,
`ifdef GF2_MUL_ACC_EN
    input  logic                acc_en,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [AW+M-2:0]     c,
    output logic                busy
);

    localparam int N     = (AW + D - 1) / D;
    localparam int PW    = N * D;
    localparam int ACW   = PW + M - 1;
    localparam int CW    = AW + M - 1;
    localparam int PPW   = D + M - 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PW-1:0]     r_a;
    logic [M-1:0]      r_b;
    logic [ACW-1:0]    r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_drain;
    logic [CW-1:0]     r_c;

    logic              w_accept;
    logic [D-1:0]      w_digit;
    logic [PPW-1:0]    w_pp;
    logic [CW-1:0]     w_result;

    assign w_accept = in_valid && in_ready;
    assign w_digit  = r_a[PW-1 -: D];
    assign c        = r_c;

`ifdef GF2_MUL_ACC_EN
    logic r_acc_en;
    assign w_result = r_acc_en ? (r_acc[CW-1:0] ^ r_c) : r_acc[CW-1:0];
`else
    assign w_result = r_acc[CW-1:0];
`endif

    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_drain) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Carry-less digit x b: shifted copies of b XORed together.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < D; i++) begin
            if (w_digit[i]) w_pp = w_pp ^ (PPW'(r_b) << i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_c     <= '0;
`ifdef GF2_MUL_ACC_EN
            r_acc_en <= 1'b0;
`endif
        end else if (w_accept) begin
            r_acc   <= '0;
            r_cnt   <= CNT_W'(N - 1);
            r_drain <= 1'b0;
`ifdef GF2_MUL_ACC_EN
            r_acc_en <= acc_en;
`endif
        end else if (r_state == S_RUN) begin
            if (r_drain) begin
                // Padding digits are zero, so nothing can land above the product width.
                assert ((r_acc >> CW) == '0);
                r_c     <= w_result;
                r_drain <= 1'b0;
            end else begin
                r_acc <= (r_acc << D) ^ ACW'(w_pp);
                if (r_cnt == '0) r_drain <= 1'b1;
                else             r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    // NOTE: operand registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= PW'(a);
            r_b <= b;
        end else if (r_state == S_RUN && !r_drain) begin
            r_a <= r_a << D;
        end
    end

endmodule

// File: tb/tb_gf2_digit_serial_mul.sv
// Directed and randomised checks of gf2_digit_serial_mul for D = 8, 1, 7 and 41 sharing one stimulus.
module tb_gf2_digit_serial_mul;

    localparam int AW = 41;
    localparam int M  = 163;
    localparam int CW = AW + M - 1;
    localparam int NI = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic          acc_en;
    logic [AW-1:0] a;
    logic [M-1:0]  b;

    logic          in_ready  [NI];
    logic          out_valid [NI];
    logic          busy      [NI];
    logic [CW-1:0] c         [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf2_digit_serial_mul #(.AW(AW), .M(M), .D(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
`ifdef GF2_MUL_ACC_EN
        .acc_en(acc_en),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready), .c(c[0]), .busy(busy[0]));

    gf2_digit_serial_mul #(.AW(AW), .M(M), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
`ifdef GF2_MUL_ACC_EN
        .acc_en(acc_en),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready), .c(c[1]), .busy(busy[1]));

    gf2_digit_serial_mul #(.AW(AW), .M(M), .D(7)) u_d7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b),
`ifdef GF2_MUL_ACC_EN
        .acc_en(acc_en),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready), .c(c[2]), .busy(busy[2]));

    gf2_digit_serial_mul #(.AW(AW), .M(M), .D(41)) u_d41 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .a(a), .b(b),
`ifdef GF2_MUL_ACC_EN
        .acc_en(acc_en),
`endif
        .out_valid(out_valid[3]), .out_ready(out_ready), .c(c[3]), .busy(busy[3]));

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-at-a-time reference product.
    function automatic logic [CW-1:0] clmul(input logic [AW-1:0] x, input logic [M-1:0] y);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            if (x[i]) r = r ^ (CW'(y) << i);
        end
        return r;
    endfunction

    task automatic wait_all_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid[0] && out_valid[1] && out_valid[2] && out_valid[3]) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_all(input string tag, input logic [CW-1:0] exp);
        for (int i = 0; i < NI; i++) check($sformatf("%s_i%0d", tag, i), c[i], exp);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [AW-1:0] av, input logic [M-1:0] bv,
                          input logic accv, input logic [CW-1:0] exp);
        bit ok;
        @(negedge clk);
        a        = av;
        b        = bv;
        acc_en   = accv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        wait_all_done(ok);
        check({tag, "_done"}, CW'(ok), CW'(1));
        check_all(tag, exp);
        release_result();
    endtask

    initial begin
        bit            ok;
        bit            saw_valid;
        logic [AW-1:0] ra;
        logic [M-1:0]  rb;
        logic [CW-1:0] exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc_en    = 1'b0;
        a         = '0;
        b         = '0;

        #1;
        check("rst_in_ready", CW'(in_ready[0]), CW'(1));
        check("rst_out_valid", CW'(out_valid[0]), CW'(0));
        check("rst_busy", CW'(busy[0]), CW'(0));
        check("rst_c", c[0], '0);

        // a=1, b=1 offered together with reset release: accepted on the first edge.
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        a        = 41'd1;
        b        = 163'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t_e0_in_ready", CW'(in_ready[0]), CW'(0));
        check("t_e0_busy", CW'(busy[0]), CW'(1));
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            check($sformatf("t_e%0d_out_valid", e), CW'(out_valid[0]), CW'(0));
            check($sformatf("t_e%0d_in_ready", e), CW'(in_ready[0]), CW'(0));
        end
        @(negedge clk);
        check("t_e7_out_valid", CW'(out_valid[0]), CW'(1));
        check("t_e7_in_ready", CW'(in_ready[0]), CW'(0));
        check("t_e7_c", c[0], CW'(1));
        wait_all_done(ok);
        check("t_all_done", CW'(ok), CW'(1));
        check_all("t_one", CW'(1));
        release_result();

        run_op("d_3x3", 41'h3, 163'h3, 1'b0, CW'(5));
        ra  = '0; ra[40] = 1'b1;
        rb  = '0; rb[162] = 1'b1;
        exp = '0; exp[202] = 1'b1;
        run_op("d_top", ra, rb, 1'b0, exp);
        ra  = '1;
        run_op("d_ones", ra, 163'd1, 1'b0, CW'(41'h1ff_ffff_ffff));
        run_op("d_zero", 41'h0, 163'h7, 1'b0, CW'(0));

        // Result held in DONE against back-pressure, in_valid pulses ignored.
        @(negedge clk);
        a        = 41'h1f;
        b        = 163'h3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_all_done(ok);
        check("s_done", CW'(ok), CW'(1));
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a        = 41'(k + 2);
            b        = 163'(k + 5);
            @(negedge clk);
            check($sformatf("s_c_%0d", k), c[0], CW'(12'h021));
            check($sformatf("s_ov_%0d", k), CW'(out_valid[0]), CW'(1));
            check($sformatf("s_rdy_%0d", k), CW'(in_ready[0]), CW'(0));
        end
        in_valid = 1'b0;
        check_all("s_hold", CW'(12'h021));
        release_result();
        check("s_idle_rdy", CW'(in_ready[0]), CW'(1));
        check("s_idle_ov", CW'(out_valid[0]), CW'(0));
        check("s_idle_c", c[0], CW'(12'h021));

        // c keeps the previous result while the next product is in RUN.
        @(negedge clk);
        a        = 41'h3;
        b        = 163'h3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("r_run_c", c[0], CW'(12'h021));
        wait_all_done(ok);
        check("r_done", CW'(ok), CW'(1));
        check_all("r_res", CW'(5));
        release_result();

        // Reset in the third RUN cycle abandons the operation.
        @(negedge clk);
        a        = '1;
        b        = 163'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("x_out_valid", CW'(out_valid[0]), CW'(0));
        check("x_c", c[0], '0);
        check("x_in_ready", CW'(in_ready[0]), CW'(1));
        check("x_busy", CW'(busy[0]), CW'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (out_valid[i]) saw_valid = 1'b1;
        end
        check("x_no_result", CW'(saw_valid), CW'(0));
        run_op("x_after", 41'h1f, 163'h3, 1'b0, CW'(12'h021));

        run_op("acc_first", 41'h3, 163'h3, 1'b0, CW'(5));
`ifdef GF2_MUL_ACC_EN
        run_op("acc_second", 41'h1, 163'h1, 1'b1, CW'(4));
`else
        run_op("acc_second", 41'h1, 163'h1, 1'b1, CW'(1));
`endif

        for (int n = 0; n < 8; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_op($sformatf("rnd%0d", n), ra, rb, 1'b0, clmul(ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
